iq_wakeup_select: RTL and testbench

Per-entry readiness tracker and select stage sitting directly downstream of the issue-queue wakeup CAMs. It consumes the per-tag match vectors the CAMs produce for source-1 and source-2 operands and keeps registered valid/ready state per entry. Each cycle it grants the lowest-index fully-ready entry into a registered valid/ready issue handshake. It also reports free entries back to dispatch.

---
 rtl/iq_wakeup_select.sv | 130 +++++++++++++
 tb/tb_iq_wakeup_select.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_wakeup_select.sv
// Issue-queue readiness tracker and select stage.
// Keeps valid/src1-ready/src2-ready per entry, folds in qualified wakeup
// match vectors, grants the lowest-index fully ready entry into a registered
// valid/ready issue handshake, and reports free entries to dispatch.
module iq_wakeup_select #(
   parameter int DEPTH      = 16,
   parameter int INDEX      = 4,
   parameter int WAKE_PORTS = 2
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        flush_i,
   input  logic                        disp_valid_i,
   input  logic [INDEX-1:0]            disp_addr_i,
   input  logic                        disp_src1_rdy_i,
   input  logic                        disp_src2_rdy_i,
   input  logic [WAKE_PORTS*DEPTH-1:0] wake1_vect_i,
   input  logic [WAKE_PORTS*DEPTH-1:0] wake2_vect_i,
   input  logic [WAKE_PORTS-1:0]       wake_valid_i,
   output logic                        issue_valid_o,
   output logic [INDEX-1:0]            issue_index_o,
   input  logic                        issue_ready_i,
   output logic [DEPTH-1:0]            free_vect_o,
   output logic [INDEX:0]              free_cnt_o
);

   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_r1;
   logic [DEPTH-1:0] r_r2;
   logic             r_issue_valid;
   logic [INDEX-1:0] r_issue_index;

   logic [DEPTH-1:0] w_wake1;
   logic [DEPTH-1:0] w_wake2;
   logic [DEPTH-1:0] w_held;
   logic [DEPTH-1:0] w_req;
   logic [INDEX-1:0] w_grant;
   logic             w_any_req;
   logic             w_accept;
   logic             w_load;
   logic [INDEX:0]   w_free_cnt;

   assign w_accept = r_issue_valid & issue_ready_i;
   assign w_load   = ~r_issue_valid | issue_ready_i;

   // Qualify each broadcast port and OR the ports together per source.
   always_comb begin
      w_wake1 = '0;
      w_wake2 = '0;
      for (int p = 0; p < WAKE_PORTS; p++) begin
         w_wake1 = w_wake1 | (wake1_vect_i[p*DEPTH +: DEPTH] & {DEPTH{wake_valid_i[p]}});
         w_wake2 = w_wake2 | (wake2_vect_i[p*DEPTH +: DEPTH] & {DEPTH{wake_valid_i[p]}});
      end
   end

   // The entry sitting in the output register must not be granted again.
   assign w_held    = r_issue_valid ? (DEPTH'(1) << r_issue_index) : '0;
   assign w_req     = r_valid & r_r1 & r_r2 & ~w_held;
   assign w_any_req = |w_req;

   // Fixed-priority select: lowest requesting index wins.
   always_comb begin
      w_grant = '0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (w_req[i]) w_grant = INDEX'(i);
      end
   end

   // Per-entry state: flush clears everything; dispatch overwrites the entry
   // and ignores same-cycle wakeup on it; otherwise accept frees and wakeup
   // accumulates into the ready bits of live entries.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         r_r1    <= '0;
         r_r2    <= '0;
      end else if (flush_i) begin
         r_valid <= '0;
         r_r1    <= '0;
         r_r2    <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (disp_valid_i && (disp_addr_i == INDEX'(i))) begin
               r_valid[i] <= 1'b1;
               r_r1[i]    <= disp_src1_rdy_i;
               r_r2[i]    <= disp_src2_rdy_i;
            end else begin
               if (w_accept && (r_issue_index == INDEX'(i))) r_valid[i] <= 1'b0;
               if (r_valid[i]) begin
                  r_r1[i] <= r_r1[i] | w_wake1[i];
                  r_r2[i] <= r_r2[i] | w_wake2[i];
               end
            end
         end
      end
   end

   // Issue output register; holds steady while the consumer stalls.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_issue_valid <= 1'b0;
         r_issue_index <= '0;
      end else if (flush_i) begin
         r_issue_valid <= 1'b0;
      end else if (w_load) begin
         r_issue_valid <= w_any_req;
         if (w_any_req) r_issue_index <= w_grant;
      end
   end

   assign issue_valid_o = r_issue_valid;
   assign issue_index_o = r_issue_index;
   assign free_vect_o   = ~r_valid;

   // Population count of free entries.
   always_comb begin
      w_free_cnt = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_free_cnt = w_free_cnt + (INDEX+1)'(free_vect_o[i]);
      end
   end

   assign free_cnt_o = w_free_cnt;

   // Dispatch may only target a free entry; the RTL still overwrites it.
   a_disp_to_free: assert property (@(posedge clk) disable iff (!reset_n)
      disp_valid_i |-> !r_valid[disp_addr_i])
      else $error("dispatch to occupied entry %0d", disp_addr_i);

endmodule

// File: tb/tb_iq_wakeup_select.sv
// Scoreboard bench for iq_wakeup_select: directed stimulus pushes the
// expected issue order; a negedge monitor pops on every handshake.
module tb_iq_wakeup_select;

   localparam int DEPTH = 16;
   localparam int INDEX = 4;
   localparam int WP    = 2;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  flush_i;
   logic                  disp_valid_i;
   logic [INDEX-1:0]      disp_addr_i;
   logic                  disp_src1_rdy_i;
   logic                  disp_src2_rdy_i;
   logic [WP*DEPTH-1:0]   wake1_vect_i;
   logic [WP*DEPTH-1:0]   wake2_vect_i;
   logic [WP-1:0]         wake_valid_i;
   logic                  issue_valid_o;
   logic [INDEX-1:0]      issue_index_o;
   logic                  issue_ready_i;
   logic [DEPTH-1:0]      free_vect_o;
   logic [INDEX:0]        free_cnt_o;

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];

   iq_wakeup_select #(.DEPTH(DEPTH), .INDEX(INDEX), .WAKE_PORTS(WP)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .flush_i         (flush_i),
      .disp_valid_i    (disp_valid_i),
      .disp_addr_i     (disp_addr_i),
      .disp_src1_rdy_i (disp_src1_rdy_i),
      .disp_src2_rdy_i (disp_src2_rdy_i),
      .wake1_vect_i    (wake1_vect_i),
      .wake2_vect_i    (wake2_vect_i),
      .wake_valid_i    (wake_valid_i),
      .issue_valid_o   (issue_valid_o),
      .issue_index_o   (issue_index_o),
      .issue_ready_i   (issue_ready_i),
      .free_vect_o     (free_vect_o),
      .free_cnt_o      (free_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dispatch(input int a, input logic r1, input logic r2);
      disp_valid_i    = 1'b1;
      disp_addr_i     = INDEX'(a);
      disp_src1_rdy_i = r1;
      disp_src2_rdy_i = r2;
      tick();
      disp_valid_i    = 1'b0;
      disp_src1_rdy_i = 1'b0;
      disp_src2_rdy_i = 1'b0;
   endtask

   // Monitor: every handshake must match the head of the expected queue.
   always @(negedge clk) begin
      if (reset_n && issue_valid_o && issue_ready_i) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_issue: got index %0d expected none", issue_index_o);
         end else begin
            int e;
            e = exp_q.pop_front();
            if (32'(issue_index_o) != e) begin
               n_err++;
               $display("FAIL issue_order: got index %0d expected %0d", issue_index_o, e);
            end
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      flush_i = 1'b0;
      disp_valid_i = 1'b0;
      disp_addr_i = '0;
      disp_src1_rdy_i = 1'b0;
      disp_src2_rdy_i = 1'b0;
      wake1_vect_i = '0;
      wake2_vect_i = '0;
      wake_valid_i = '0;
      issue_ready_i = 1'b1;
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      // Reset state
      check("rst_issue_valid", 32'(issue_valid_o), 0);
      check("rst_issue_index", 32'(issue_index_o), 0);
      check("rst_free_cnt", 32'(free_cnt_o), 16);
      check("rst_free_vect", 32'(free_vect_o), 32'hFFFF);

      // Dispatch entry 5 fully ready: issue two edges later, freed on accept
      exp_q.push_back(5);
      dispatch(5, 1'b1, 1'b1);
      check("d5_free_bit_after_disp", 32'(free_vect_o[5]), 0);
      check("d5_valid_t1", 32'(issue_valid_o), 0);
      tick();
      check("d5_valid_t2", 32'(issue_valid_o), 1);
      check("d5_index_t2", 32'(issue_index_o), 5);
      tick();
      check("d5_free_bit_t3", 32'(free_vect_o[5]), 1);
      check("d5_valid_t3", 32'(issue_valid_o), 0);

      // Entries 3 and 9 waiting on src2
      dispatch(3, 1'b1, 1'b0);
      dispatch(9, 1'b1, 1'b0);
      // Port-1 vectors but port 1 not qualified: nothing may issue
      wake2_vect_i = 32'h0208_0000;
      wake_valid_i = 2'b00;
      tick();
      wake_valid_i = 2'b01;
      tick();
      wake_valid_i = 2'b00;
      wake2_vect_i = '0;
      tick();
      tick();
      check("nowake_valid", 32'(issue_valid_o), 0);
      check("nowake_free_cnt", 32'(free_cnt_o), 14);
      // Qualified wake on port 1
      exp_q.push_back(3);
      exp_q.push_back(9);
      wake2_vect_i = 32'h0208_0000;
      wake_valid_i = 2'b10;
      tick();
      wake2_vect_i = '0;
      wake_valid_i = 2'b00;
      check("wake_valid_t1", 32'(issue_valid_o), 0);
      tick();
      check("wake_valid_t2", 32'(issue_valid_o), 1);
      check("wake_index_t2", 32'(issue_index_o), 3);
      tick();
      check("wake_index_t3", 32'(issue_index_o), 9);
      tick();
      check("wake_empty", 32'(issue_valid_o), 0);

      // Entry 11 waiting on src1, both wake ports hit it in the same cycle
      dispatch(11, 1'b0, 1'b1);
      exp_q.push_back(11);
      wake1_vect_i = 32'h0800_0800;
      wake_valid_i = 2'b11;
      tick();
      wake1_vect_i = '0;
      wake_valid_i = 2'b00;
      tick();
      check("wake1_index", 32'(issue_index_o), 11);
      tick();
      tick();

      // Hold: 2 and 7 ready, consumer stalls for 3 cycles
      issue_ready_i = 1'b0;
      exp_q.push_back(2);
      exp_q.push_back(7);
      dispatch(2, 1'b1, 1'b1);
      dispatch(7, 1'b1, 1'b1);
      check("hold_valid", 32'(issue_valid_o), 1);
      check("hold_index_0", 32'(issue_index_o), 2);
      for (int k = 1; k <= 3; k++) begin
         tick();
         check($sformatf("hold_index_%0d", k), 32'(issue_index_o), 2);
         check($sformatf("hold_valid_%0d", k), 32'(issue_valid_o), 1);
      end
      issue_ready_i = 1'b1;
      tick();
      check("release_index", 32'(issue_index_o), 7);
      tick();
      check("release_empty", 32'(issue_valid_o), 0);
      check("release_free_cnt", 32'(free_cnt_o), 16);

      // Fill every entry with the consumer stalled
      issue_ready_i = 1'b0;
      for (int a = 0; a < DEPTH; a++) dispatch(a, 1'b1, 1'b1);
      check("full_free_cnt", 32'(free_cnt_o), 0);
      check("full_index", 32'(issue_index_o), 0);
      exp_q.push_back(0);
      issue_ready_i = 1'b1;
      tick();
      issue_ready_i = 1'b0;
      check("one_accept_free_cnt", 32'(free_cnt_o), 1);
      check("one_accept_next_index", 32'(issue_index_o), 1);

      // Flush together with a dispatch and an accept
      exp_q.push_back(1);
      flush_i = 1'b1;
      issue_ready_i = 1'b1;
      disp_valid_i = 1'b1;
      disp_addr_i = 4'd0;
      disp_src1_rdy_i = 1'b1;
      disp_src2_rdy_i = 1'b1;
      tick();
      flush_i = 1'b0;
      disp_valid_i = 1'b0;
      disp_src1_rdy_i = 1'b0;
      disp_src2_rdy_i = 1'b0;
      check("flush_valid", 32'(issue_valid_o), 0);
      check("flush_free_cnt", 32'(free_cnt_o), 16);
      check("flush_free_vect", 32'(free_vect_o), 32'hFFFF);
      tick();
      tick();
      check("flush_stays_empty", 32'(issue_valid_o), 0);

      // Asynchronous reset while a grant is held
      issue_ready_i = 1'b0;
      dispatch(6, 1'b1, 1'b1);
      tick();
      check("prereset_valid", 32'(issue_valid_o), 1);
      check("prereset_index", 32'(issue_index_o), 6);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_valid", 32'(issue_valid_o), 0);
      check("async_rst_index", 32'(issue_index_o), 0);
      check("async_rst_free_cnt", 32'(free_cnt_o), 16);
      tick();
      reset_n = 1'b1;
      issue_ready_i = 1'b1;
      tick();
      tick();
      check("post_reset_valid", 32'(issue_valid_o), 0);
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
